// File: rtl/btn_debounce_pulse_pkg.sv
// Shared helpers for the push-button conditioning block.
package btn_debounce_pulse_pkg;

  // Stability counter width; never narrower than one bit so DEBOUNCE_CYCLES=1 still elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser chain, stability counter, debounced level and edge strobes.
module btn_debounce_ch
  import btn_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          INACTIVE = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [CW-1:0]          cnt;
  logic                   s;

  // Normalised synchronised sample, 1 = pressed regardless of pin polarity.
  assign s = sync_p[SYNC_STAGES-1] ^ INACTIVE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p      <= {SYNC_STAGES{INACTIVE}};
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync_p      <= {sync_p[SYNC_STAGES-2:0], btn_raw};
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Change accepted: strobe shares the cycle in which the new level first appears.
        btn_level   <= s;
        cnt         <= '0;
        btn_press   <= s;
        btn_release <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// N independent debounced push-button channels with clean level and press/release strobes.
module btn_debounce_pulse #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule
